// File: rtl/bit_collector.sv
// Serial-to-parallel byte collector with LSB/MSB-first ordering, abort and output handshake.
// Optional even-parity bit after each byte when BIT_COLLECTOR_PARITY_EN is defined.
module bit_collector (
    input  logic       clk,
    input  logic       rst,
    input  logic       dir,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    input  logic       abort,
    output logic [7:0] O,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic [3:0] count,
    output logic       parity_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
`ifdef BIT_COLLECTOR_PARITY_EN
        PAR     = 2'd2,
`endif
        HOLD    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [3:0]  count_q, count_d;
    logic        dir_q, dir_d;
    logic        accept;
    logic        eff_dir;
    logic [7:0]  shifted;
`ifdef BIT_COLLECTOR_PARITY_EN
    logic        perr_q, perr_d;
`endif

    assign accept  = bit_valid && bit_ready;
    // The first bit of a byte takes the live dir; later bits follow the latched copy.
    assign eff_dir = (state_q == IDLE) ? dir : dir_q;
    assign shifted = eff_dir ? {shreg_q[6:0], bit_in} : {bit_in, shreg_q[7:1]};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        dir_d   = dir_q;
`ifdef BIT_COLLECTOR_PARITY_EN
        perr_d  = perr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    dir_d   = dir;
                    shreg_d = shifted;
                    count_d = 4'd1;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (abort) begin
                    count_d = 4'd0;
                    state_d = IDLE;
                end else if (accept) begin
                    shreg_d = shifted;
                    count_d = count_q + 4'd1;
                    if (count_q == 4'd7) begin
`ifdef BIT_COLLECTOR_PARITY_EN
                        state_d = PAR;
`else
                        state_d = HOLD;
`endif
                    end
                end
            end
`ifdef BIT_COLLECTOR_PARITY_EN
            PAR: begin
                if (abort) begin
                    count_d = 4'd0;
                    state_d = IDLE;
                end else if (accept) begin
                    count_d = count_q + 4'd1;
                    perr_d  = (^shreg_q) ^ bit_in;
                    state_d = HOLD;
                end
            end
`endif
            HOLD: begin
                if (out_ready) begin
                    count_d = 4'd0;
                    state_d = IDLE;
`ifdef BIT_COLLECTOR_PARITY_EN
                    perr_d  = 1'b0;
`endif
                end
            end
            default: begin
                count_d = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= 8'h00;
            count_q <= 4'd0;
            dir_q   <= 1'b0;
`ifdef BIT_COLLECTOR_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            dir_q   <= dir_d;
`ifdef BIT_COLLECTOR_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign O         = shreg_q;
    assign count     = count_q;
    assign out_valid = (state_q == HOLD);
    assign bit_ready = (state_q != HOLD);
`ifdef BIT_COLLECTOR_PARITY_EN
    assign busy       = (state_q == COLLECT) || (state_q == PAR);
    assign parity_err = perr_q;
`else
    assign busy       = (state_q == COLLECT);
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_bit_collector.sv
// Directed self-checking bench for bit_collector; inputs driven and outputs sampled on the falling edge.
module tb_bit_collector;

    logic       clk = 1'b0;
    logic       rst, dir, bit_in, bit_valid, abort, out_ready;
    logic       bit_ready, out_valid, busy, parity_err;
    logic [7:0] O;
    logic [3:0] count;

    int vectors = 0;
    int miscompares = 0;

`ifdef BIT_COLLECTOR_PARITY_EN
    localparam logic [3:0] FULL = 4'd9;
`else
    localparam logic [3:0] FULL = 4'd8;
`endif

    bit_collector dut (
        .clk(clk), .rst(rst), .dir(dir), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .abort(abort), .O(O), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .count(count), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    // Sends 8 bits, first bit = seq[7]; first bit uses d0, the rest dmid. Ends on a falling edge with bit_valid=0.
    task automatic send_bits(input logic d0, input logic dmid, input logic [7:0] seq);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 7) begin
                if (count !== 4'd7 || out_valid !== 1'b0) begin
                    $display("FAIL pre_last_bit: count=%0d out_valid=%b want 7/0", count, out_valid);
                    miscompares++;
                end
                vectors++;
            end
            bit_valid = 1'b1;
            bit_in    = seq[7-i];
            dir       = (i == 0) ? d0 : dmid;
        end
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    // Appends the parity bit when the parity build is selected; no-op otherwise.
    task automatic complete_byte(input logic pbit);
`ifdef BIT_COLLECTOR_PARITY_EN
        if (out_valid !== 1'b0 || count !== 4'd8 || busy !== 1'b1) begin
            $display("FAIL par_state: out_valid=%b count=%0d busy=%b want 0/8/1", out_valid, count, busy);
            miscompares++;
        end
        vectors++;
        bit_valid = 1'b1;
        bit_in    = pbit;
        @(negedge clk);
        bit_valid = 1'b0;
`else
        bit_in = pbit;
`endif
    endtask

    task automatic check_byte(input string name, input logic [7:0] exp);
        if (out_valid !== 1'b1 || O !== exp || count !== FULL || busy !== 1'b0 || bit_ready !== 1'b0) begin
            $display("FAIL %s: out_valid=%b O=%h count=%0d busy=%b bit_ready=%b want 1/%h/%0d/0/0",
                     name, out_valid, O, count, busy, bit_ready, exp, FULL);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (out_valid !== 1'b0 || count !== 4'd0 || bit_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL take: out_valid=%b count=%0d bit_ready=%b busy=%b want 0/0/1/0",
                     out_valid, count, bit_ready, busy);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_reset();
        rst = 1'b1; dir = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        if (O !== 8'h00 || count !== 4'd0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            bit_ready !== 1'b1 || parity_err !== 1'b0) begin
            $display("FAIL reset: O=%h count=%0d ov=%b busy=%b br=%b perr=%b want 00/0/0/0/1/0",
                     O, count, out_valid, busy, bit_ready, parity_err);
            miscompares++;
        end
        vectors++;
        rst = 1'b0;
    endtask

    task automatic test_order();
        send_bits(1'b0, 1'b0, 8'b1010_0101);
        complete_byte(1'b0);
        check_byte("lsb_first_a5", 8'hA5);
        if (parity_err !== 1'b0) begin
            $display("FAIL perr_clean: got %b want 0", parity_err);
            miscompares++;
        end
        vectors++;
        take();
        send_bits(1'b1, 1'b1, 8'b1010_0101);
        complete_byte(1'b0);
        check_byte("msb_first_a5", 8'hA5);
        take();
        send_bits(1'b0, 1'b0, 8'b1100_0000);
        complete_byte(1'b0);
        check_byte("lsb_first_03", 8'h03);
        take();
        send_bits(1'b1, 1'b1, 8'b1100_0000);
        complete_byte(1'b0);
        check_byte("msb_first_c0", 8'hC0);
        take();
        // dir flips after the first bit; the byte must stay MSB-first.
        send_bits(1'b1, 1'b0, 8'b1100_0000);
        complete_byte(1'b0);
        check_byte("dir_latched", 8'hC0);
        take();
    endtask

    task automatic test_back_pressure();
        send_bits(1'b0, 1'b0, 8'b1010_0101);
        complete_byte(1'b0);
        bit_valid = 1'b1; bit_in = 1'b1; abort = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_byte("hold_stable", 8'hA5);
        end
        abort = 1'b0;
        out_ready = 1'b1;
        if (bit_ready !== 1'b0) begin
            $display("FAIL take_cycle_ready: got %b want 0", bit_ready);
            miscompares++;
        end
        vectors++;
        @(negedge clk);
        out_ready = 1'b0;
        bit_valid = 1'b0;
        if (out_valid !== 1'b0 || count !== 4'd0 || busy !== 1'b0 || bit_ready !== 1'b1) begin
            $display("FAIL after_take: ov=%b count=%0d busy=%b br=%b want 0/0/0/1",
                     out_valid, count, busy, bit_ready);
            miscompares++;
        end
        vectors++;
        // out_ready in IDLE must not disturb anything.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (out_valid !== 1'b0 || busy !== 1'b0 || count !== 4'd0) begin
            $display("FAIL idle_out_ready: ov=%b busy=%b count=%0d want 0/0/0", out_valid, busy, count);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_abort();
        // abort is ignored in IDLE, so the first bit is still taken.
        bit_valid = 1'b1; bit_in = 1'b1; dir = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        if (count !== 4'd1 || busy !== 1'b1) begin
            $display("FAIL idle_abort: count=%0d busy=%b want 1/1", count, busy);
            miscompares++;
        end
        vectors++;
        repeat (2) @(negedge clk);
        if (count !== 4'd3 || busy !== 1'b1) begin
            $display("FAIL three_bits: count=%0d busy=%b want 3/1", count, busy);
            miscompares++;
        end
        vectors++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; bit_valid = 1'b0;
        if (count !== 4'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL abort: count=%0d busy=%b ov=%b want 0/0/0", count, busy, out_valid);
            miscompares++;
        end
        vectors++;
        send_bits(1'b0, 1'b0, 8'b0011_1100);
        complete_byte(1'b0);
        check_byte("after_abort_3c", 8'h3C);
        take();
    endtask

    task automatic test_reset_in_hold();
        send_bits(1'b0, 1'b0, 8'b1010_0101);
        complete_byte(1'b0);
        check_byte("pre_reset_hold", 8'hA5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if (out_valid !== 1'b0 || O !== 8'h00 || bit_ready !== 1'b1 || count !== 4'd0 || busy !== 1'b0) begin
            $display("FAIL reset_in_hold: ov=%b O=%h br=%b count=%0d busy=%b want 0/00/1/0/0",
                     out_valid, O, bit_ready, count, busy);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_reset_mid_byte();
        bit_valid = 1'b1; bit_in = 1'b1; dir = 1'b1;
        repeat (4) @(negedge clk);
        bit_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if (count !== 4'd0 || busy !== 1'b0 || O !== 8'h00) begin
            $display("FAIL reset_mid_byte: count=%0d busy=%b O=%h want 0/0/00", count, busy, O);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_parity();
`ifdef BIT_COLLECTOR_PARITY_EN
        send_bits(1'b0, 1'b0, 8'b1010_0101);
        complete_byte(1'b0);
        check_byte("par_good", 8'hA5);
        if (parity_err !== 1'b0) begin
            $display("FAIL par_good_err: got %b want 0", parity_err);
            miscompares++;
        end
        vectors++;
        take();
        send_bits(1'b0, 1'b0, 8'b1010_0101);
        complete_byte(1'b1);
        check_byte("par_bad", 8'hA5);
        if (parity_err !== 1'b1) begin
            $display("FAIL par_bad_err: got %b want 1", parity_err);
            miscompares++;
        end
        vectors++;
        take();
`else
        @(negedge clk);
        if (parity_err !== 1'b0) begin
            $display("FAIL perr_tied: got %b want 0", parity_err);
            miscompares++;
        end
        vectors++;
`endif
    endtask

    initial begin
        test_reset();
        test_order();
        test_back_pressure();
        test_abort();
        test_reset_in_hold();
        test_reset_mid_byte();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
